// File: rtl/mux_b_pipe.sv
// mux_b_pipe: registered ALU operand-B source multiplexer with a valid/ready
// handshake and a 2-entry skid buffer (main register M plus skid register S).
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is registered)
//   selector, data_b,      operand form select and candidate sources
//   data_alt, imm
//   out_valid / out_ready  downstream handshake
//   data_out, sel_out      selected operand and the selector that produced it
//   err                    sticky illegal-selector flag
//
// Build option: define MUX_B_ILLEGAL_CHK_EN to turn selector 7 into result 0
// with a sticky err flag. When undefined, selector 7 aliases selector 0 and
// err is tied low.
module mux_b_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned SHIFT_AMT = 2,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        selector,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_alt,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        sel_out,
    output logic              err
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [2:0]        m_sel_q, m_sel_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [2:0]        s_sel_q, s_sel_d;

    logic              accept;
    logic              present;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] result;

    assign accept   = in_valid && in_ready_q;
    assign present  = out_valid_q && out_ready;
    assign sext_imm = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

    // Operand form selection
    always_comb begin
        result = data_b;
        unique case (selector)
            3'd0: result = data_b;
            3'd1: result = DATA_W'(CONST_VAL);
            3'd2: result = sext_imm;
            3'd3: result = sext_imm << SHIFT_AMT;
            3'd4: result = {{(DATA_W - IMM_W){1'b0}}, imm};
            3'd5: result = {imm, {(DATA_W - IMM_W){1'b0}}};
            3'd6: result = data_alt;
`ifdef MUX_B_ILLEGAL_CHK_EN
            3'd7: result = '0;
`else
            3'd7: result = data_b;
`endif
            default: result = data_b;
        endcase
    end

    // Skid-buffer state machine
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_sel_d  = m_sel_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    m_data_d = result;
                    m_sel_d  = selector;
                    state_d  = StOne;
                end
            end
            StOne: begin
                if (accept && present) begin
                    m_data_d = result;
                    m_sel_d  = selector;
                end else if (present) begin
                    state_d = StEmpty;
                end else if (accept) begin
                    s_data_d = result;
                    s_sel_d  = selector;
                    state_d  = StFull;
                end
            end
            StFull: begin
                // in_ready is low here, so only a present can occur
                if (present) begin
                    m_data_d = s_data_q;
                    m_sel_d  = s_sel_q;
                    state_d  = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_data_q    <= '0;
            m_sel_q     <= '0;
            s_data_q    <= '0;
            s_sel_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            m_data_q    <= m_data_d;
            m_sel_q     <= m_sel_d;
            s_data_q    <= s_data_d;
            s_sel_q     <= s_sel_d;
        end
    end

`ifdef MUX_B_ILLEGAL_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (accept && (selector == 3'd7));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = m_data_q;
    assign sel_out   = m_sel_q;

endmodule

// File: tb/tb_mux_b_pipe.sv
module tb_mux_b_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0]  selector, sel_out;
    logic [31:0] data_b, data_alt, data_out;
    logic [15:0] imm;

    logic        in_valid_64, in_ready_64, out_valid_64, err_64;
    logic [2:0]  sel_out_64;
    logic [63:0] data_out_64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_b_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .selector  (selector),
        .data_b    (data_b),
        .data_alt  (data_alt),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .err       (err)
    );

    mux_b_pipe #(
        .DATA_W    (64),
        .IMM_W     (16),
        .SHIFT_AMT (3)
    ) u_dut_64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_64),
        .in_ready  (in_ready_64),
        .selector  (3'd3),
        .data_b    (64'h0),
        .data_alt  (64'h0),
        .imm       (16'h8001),
        .out_valid (out_valid_64),
        .out_ready (1'b1),
        .data_out  (data_out_64),
        .sel_out   (sel_out_64),
        .err       (err_64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] forms_exp [7];
    logic [31:0] illegal_exp;

    initial begin
        forms_exp[0] = 32'h12345678;
        forms_exp[1] = 32'h00000004;
        forms_exp[2] = 32'hFFFFFFFE;
        forms_exp[3] = 32'hFFFFFFF8;
        forms_exp[4] = 32'h0000FFFE;
        forms_exp[5] = 32'hFFFE0000;
        forms_exp[6] = 32'hCAFEF00D;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_valid_64 = 1'b0;
        out_ready   = 1'b1;
        selector    = 3'd0;
        data_b      = 32'h12345678;
        data_alt    = 32'hCAFEF00D;
        imm         = 16'hFFFE;
        step();
        step();
        reset = 1'b0;
        step();

        check_eq("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("reset_data_out", {32'd0, data_out}, 64'd0);
        check_eq("reset_sel_out", {61'd0, sel_out}, 64'd0);
        check_eq("reset_err", {63'd0, err}, 64'd0);

        // All operand forms, back to back
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            selector = 3'(i);
            step();
            check_eq($sformatf("form%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check_eq($sformatf("form%0d_data", i), {32'd0, data_out}, {32'd0, forms_exp[i]});
            check_eq($sformatf("form%0d_sel", i), {61'd0, sel_out}, 64'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("drain_valid", {63'd0, out_valid}, 64'd0);
        check_eq("drain_keep_data", {32'd0, data_out}, 64'hCAFEF00D);
        check_eq("drain_keep_sel", {61'd0, sel_out}, 64'd6);

        // Stall: two accepts fill M and S, third is held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd1;
        step();
        check_eq("stall1_ready", {63'd0, in_ready}, 64'd1);
        selector = 3'd0;
        step();
        check_eq("stall2_ready", {63'd0, in_ready}, 64'd0);
        selector = 3'd2;
        step();
        check_eq("stall3_ready", {63'd0, in_ready}, 64'd0);
        check_eq("stall3_data", {32'd0, data_out}, 64'h4);

        // Hold while stalled, in_valid toggling
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            step();
            check_eq($sformatf("hold%0d_data", i), {32'd0, data_out}, 64'h4);
            check_eq($sformatf("hold%0d_sel", i), {61'd0, sel_out}, 64'd1);
        end

        // Release: order must be 4, data_b, sext(imm)
        in_valid  = 1'b1;
        selector  = 3'd2;
        out_ready = 1'b1;
        step();
        check_eq("rel1_data", {32'd0, data_out}, 64'h12345678);
        check_eq("rel1_sel", {61'd0, sel_out}, 64'd0);
        check_eq("rel1_ready", {63'd0, in_ready}, 64'd1);
        step();
        check_eq("rel2_data", {32'd0, data_out}, 64'hFFFFFFFE);
        check_eq("rel2_sel", {61'd0, sel_out}, 64'd2);
        in_valid = 1'b0;
        step();
        check_eq("rel3_valid", {63'd0, out_valid}, 64'd0);

        // Illegal selector
`ifdef MUX_B_ILLEGAL_CHK_EN
        illegal_exp = 32'h0;
`else
        illegal_exp = 32'h12345678;
`endif
        in_valid = 1'b1;
        selector = 3'd7;
        step();
        in_valid = 1'b0;
        check_eq("illegal_data", {32'd0, data_out}, {32'd0, illegal_exp});
        check_eq("illegal_sel", {61'd0, sel_out}, 64'd7);
`ifdef MUX_B_ILLEGAL_CHK_EN
        check_eq("illegal_err", {63'd0, err}, 64'd1);
        step();
        step();
        check_eq("illegal_err_sticky", {63'd0, err}, 64'd1);
`else
        check_eq("illegal_err", {63'd0, err}, 64'd0);
        step();
`endif

        // Wide instance: sext(8001) << 3 in 64 bits
        in_valid_64 = 1'b1;
        step();
        in_valid_64 = 1'b0;
        check_eq("w64_valid", {63'd0, out_valid_64}, 64'd1);
        check_eq("w64_data", data_out_64, 64'hFFFFFFFFFFFC0008);
        check_eq("w64_err", {63'd0, err_64}, 64'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd6;
        step();
        step();
        in_valid = 1'b0;
        check_eq("full_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        check_eq("arst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_ready", {63'd0, in_ready}, 64'd1);
        check_eq("arst_data", {32'd0, data_out}, 64'd0);
        check_eq("arst_sel", {61'd0, sel_out}, 64'd0);
        check_eq("arst_err", {63'd0, err}, 64'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("post_arst_valid", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
